// File: rtl/shared_port_arbiter_if.sv
// shared_port_arbiter_if: requester and shared-port signals around the arbiter
interface shared_port_arbiter_if #(parameter int DATA_WIDTH = 32);
  logic req0, req1;
  logic [DATA_WIDTH-1:0] addr0, addr1, w_data0, w_data1;
  logic mem_done;
  logic gnt0, gnt1, done0, done1, mem_valid, sel;
  logic [DATA_WIDTH-1:0] mem_addr, mem_w_data;
  modport master (
    output req0, req1, addr0, addr1, w_data0, w_data1, mem_done,
    input gnt0, gnt1, done0, done1, mem_valid, sel, mem_addr, mem_w_data
  );
  modport slave (
    input req0, req1, addr0, addr1, w_data0, w_data1, mem_done,
    output gnt0, gnt1, done0, done1, mem_valid, sel, mem_addr, mem_w_data
  );
endinterface

// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter: two-requester round-robin arbiter owning the shared-port mux select.
// Define SHARED_PORT_ARB_TIMEOUT_EN to force-release grants held MAX_HOLD cycles without completion.
module shared_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  parameter int MAX_HOLD = 64
) (
  input  logic clk,
  input  logic rst_n,
  shared_port_arbiter_if.slave bus,
  output logic [CNT_WIDTH-1:0] grant_cnt0_o,
  output logic [CNT_WIDTH-1:0] grant_cnt1_o,
  output logic timeout_err_o
);
  localparam logic [1:0] IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2;
  logic [1:0] state_q, state_d, flip;
  logic sel_q, last_q, gnt0, gnt1, own, other, ent0, ent1, tmo;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;
  assign gnt0 = state_q == GRANT0;
  assign gnt1 = state_q == GRANT1;
  assign own = gnt0 ? bus.req0 : bus.req1;
  assign other = gnt0 ? bus.req1 : bus.req0;
  assign flip = gnt0 ? GRANT1 : GRANT0;
  always_comb begin
    state_d = !(gnt0 || gnt1) ?
                ((bus.req0 && bus.req1) ? (last_q ? GRANT0 : GRANT1) :
                 bus.req0 ? GRANT0 : bus.req1 ? GRANT1 : IDLE) :
              bus.mem_done ? (other ? flip : own ? state_q : IDLE) :
              tmo ? (other ? flip : IDLE) :
              own ? state_q : IDLE;
  end
  // a completion while staying in the same grant state is a re-grant
  assign ent0 = state_d == GRANT0 && (!gnt0 || bus.mem_done);
  assign ent1 = state_d == GRANT1 && (!gnt1 || bus.mem_done);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      last_q <= 1'b1;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= ent1 ? 1'b1 : ent0 ? 1'b0 : sel_q;
      last_q <= ent1 ? 1'b1 : ent0 ? 1'b0 : last_q;
      cnt0_q <= cnt0_q + CNT_WIDTH'(ent0 && !(&cnt0_q));
      cnt1_q <= cnt1_q + CNT_WIDTH'(ent1 && !(&cnt1_q));
    end
  end
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0] hold_q;
  logic terr_q;
  assign tmo = (gnt0 || gnt1) && !bus.mem_done && hold_q == HW'(MAX_HOLD - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      terr_q <= 1'b0;
    end else begin
      hold_q <= (ent0 || ent1) ? '0 : ((gnt0 || gnt1) && !bus.mem_done) ? hold_q + 1'b1 : hold_q;
      terr_q <= terr_q | tmo;
    end
  end
  assign timeout_err_o = terr_q;
`else
  assign tmo = 1'b0;
  assign timeout_err_o = MAX_HOLD < 1;
`endif
  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;
  assign bus.done0 = bus.mem_done && gnt0;
  assign bus.done1 = bus.mem_done && gnt1;
  assign bus.mem_valid = gnt0 || gnt1;
  assign bus.sel = sel_q;
  assign bus.mem_addr = DATA_WIDTH'(sel_q ? bus.addr1 : bus.addr0);
  assign bus.mem_w_data = DATA_WIDTH'(sel_q ? bus.w_data1 : bus.w_data0);
  assign grant_cnt0_o = cnt0_q;
  assign grant_cnt1_o = cnt1_q;
endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb_shared_port_arbiter: scenario tasks plus a completion scoreboard for shared_port_arbiter
module tb_shared_port_arbiter;
  localparam int DW = 32, CW = 4, MH = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [CW-1:0] cnt0, cnt1;
  logic terr;
  always #5 clk = ~clk;
  shared_port_arbiter_if #(.DATA_WIDTH(DW)) bus();
  shared_port_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_cnt0_o(cnt0), .grant_cnt1_o(cnt1), .timeout_err_o(terr)
  );
  typedef struct {
    logic id;
    logic [DW-1:0] addr;
    logic [DW-1:0] wd;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int passed = 0, total = 0;

  // every done pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
      total++;
      if (sb.size() == 0)
        $display("FAIL done_unexpected: done0=%b done1=%b, required no done", bus.done0, bus.done1);
      else begin
        mon_e = sb.pop_front();
        if (bus.done1 !== mon_e.id || bus.done0 === bus.done1 || bus.mem_addr !== mon_e.addr || bus.mem_w_data !== mon_e.wd)
          $display("FAIL done_txn: done0=%b done1=%b addr=%h wd=%h, required id=%0d addr=%h wd=%h",
                   bus.done0, bus.done1, bus.mem_addr, bus.mem_w_data, mon_e.id, mon_e.addr, mon_e.wd);
        else passed++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.mem_done = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.w_data0 = '0; bus.w_data1 = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) begin
      bus.req0 = 1'($urandom); bus.req1 = 1'($urandom); bus.mem_done = 1'($urandom);
      bus.addr0 = $urandom; bus.addr1 = $urandom; bus.w_data0 = $urandom; bus.w_data1 = $urandom;
      tick();
    end
    total++;
    if ({bus.gnt0, bus.gnt1, bus.sel, bus.mem_valid, terr} !== 5'b0)
      $display("FAIL reset_flags: gnt0,gnt1,sel,valid,terr=%b required 00000", {bus.gnt0, bus.gnt1, bus.sel, bus.mem_valid, terr});
    else passed++;
    total++;
    if (cnt0 !== 4'd0 || cnt1 !== 4'd0) $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d required 0 0", cnt0, cnt1);
    else passed++;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 32'h100; bus.w_data0 = 32'hDEAD0001;
    tick();
    total++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.mem_valid !== 1'b1 || bus.sel !== 1'b0)
      $display("FAIL single_grant: gnt0=%b gnt1=%b valid=%b sel=%b required 1 0 1 0", bus.gnt0, bus.gnt1, bus.mem_valid, bus.sel);
    else passed++;
    total++;
    if (bus.mem_addr !== 32'h100) $display("FAIL single_addr: mem_addr=%h required 00000100", bus.mem_addr);
    else passed++;
    tick();
    tick();
    total++;
    if (bus.gnt0 !== 1'b1 || bus.done0 !== 1'b0) $display("FAIL single_hold: gnt0=%b done0=%b required 1 0", bus.gnt0, bus.done0);
    else passed++;
    sb.push_back('{1'b0, 32'h100, 32'hDEAD0001});
    bus.mem_done = 1'b1; bus.req0 = 1'b0;
    tick();
    bus.mem_done = 1'b0;
    total++;
    if (bus.gnt0 !== 1'b0 || bus.mem_valid !== 1'b0 || cnt0 !== 4'd1)
      $display("FAIL single_end: gnt0=%b valid=%b cnt0=%0d required 0 0 1", bus.gnt0, bus.mem_valid, cnt0);
    else passed++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 32'h200; bus.w_data0 = 32'h11;
    tick();
    sb.push_back('{1'b0, 32'h200, 32'h11});
    bus.mem_done = 1'b1;
    tick();
    total++;
    if (bus.gnt0 !== 1'b1 || cnt0 !== 4'd2) $display("FAIL regrant: gnt0=%b cnt0=%0d required 1 2", bus.gnt0, cnt0);
    else passed++;
    bus.addr0 = 32'h204; bus.w_data0 = 32'h22; bus.req0 = 1'b0;
    sb.push_back('{1'b0, 32'h204, 32'h22});
    tick();
    bus.mem_done = 1'b0;
    total++;
    if (bus.gnt0 !== 1'b0 || cnt0 !== 4'd2) $display("FAIL regrant_end: gnt0=%b cnt0=%0d required 0 2", bus.gnt0, cnt0);
    else passed++;
  endtask

  task automatic test_tie;
    logic id;
    do_reset();
    bus.addr0 = 32'hA0; bus.w_data0 = 32'h1000; bus.addr1 = 32'hB1; bus.w_data1 = 32'h2001;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      id = 1'(i % 2);
      total++;
      if (bus.gnt0 !== !id || bus.gnt1 !== id || bus.sel !== id)
        $display("FAIL tie_order%0d: gnt0=%b gnt1=%b sel=%b required %b %b %b", i, bus.gnt0, bus.gnt1, bus.sel, !id, id, id);
      else passed++;
      sb.push_back('{id, id ? 32'hB1 : 32'hA0, id ? 32'h2001 : 32'h1000});
      bus.mem_done = 1'b1;
      if (i == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      tick();
    end
    bus.mem_done = 1'b0;
    total++;
    if (cnt0 !== 4'd2 || cnt1 !== 4'd2 || bus.mem_valid !== 1'b0)
      $display("FAIL tie_counts: cnt0=%0d cnt1=%0d valid=%b required 2 2 0", cnt0, cnt1, bus.mem_valid);
    else passed++;
  endtask

  task automatic test_abort;
    do_reset();
    bus.req1 = 1'b1; bus.addr1 = 32'h300;
    tick();
    total++;
    if (bus.gnt1 !== 1'b1 || bus.sel !== 1'b1) $display("FAIL abort_grant: gnt1=%b sel=%b required 1 1", bus.gnt1, bus.sel);
    else passed++;
    tick();
    bus.req1 = 1'b0;
    tick();
    total++;
    if (bus.gnt1 !== 1'b0 || cnt1 !== 4'd1) $display("FAIL abort_drop: gnt1=%b cnt1=%0d required 0 1", bus.gnt1, cnt1);
    else passed++;
    total++;
    if (bus.sel !== 1'b1) $display("FAIL abort_sel_hold: sel=%b required 1", bus.sel);
    else passed++;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    total++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || cnt0 !== 4'd0 || cnt1 !== 4'd1)
      $display("FAIL idle_done: gnt0=%b gnt1=%b cnt0=%0d cnt1=%0d required 0 0 0 1", bus.gnt0, bus.gnt1, cnt0, cnt1);
    else passed++;
    bus.req0 = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    total++;
    if (bus.gnt0 !== 1'b0 || cnt0 !== 4'd0) $display("FAIL reset_mid: gnt0=%b cnt0=%0d required 0 0", bus.gnt0, cnt0);
    else passed++;
    bus.req0 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_saturation;
    logic [CW-1:0] exp_cnt;
    do_reset();
    bus.addr0 = 32'h400; bus.w_data0 = 32'h55;
    for (int i = 0; i < 20; i++) begin
      bus.req0 = 1'b1;
      tick();
      sb.push_back('{1'b0, 32'h400, 32'h55});
      bus.mem_done = 1'b1; bus.req0 = 1'b0;
      tick();
      bus.mem_done = 1'b0;
      exp_cnt = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      total++;
      if (cnt0 !== exp_cnt) $display("FAIL sat_cnt%0d: cnt0=%0d required %0d", i, cnt0, exp_cnt);
      else passed++;
    end
  endtask

`ifdef SHARED_PORT_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic held;
    do_reset();
    bus.req0 = 1'b1; bus.addr1 = 32'h500; bus.w_data1 = 32'h66;
    tick();
    bus.req1 = 1'b1;
    held = 1'b1;
    repeat (7) begin
      tick();
      held = held & bus.gnt0 & !terr;
    end
    total++;
    if (held !== 1'b1) $display("FAIL timeout_hold: gnt0 held=%b required 1", held);
    else passed++;
    tick();
    total++;
    if (bus.gnt1 !== 1'b1 || terr !== 1'b1) $display("FAIL timeout_fire: gnt1=%b terr=%b required 1 1", bus.gnt1, terr);
    else passed++;
    sb.push_back('{1'b1, 32'h500, 32'h66});
    bus.mem_done = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    bus.mem_done = 1'b0;
    total++;
    if (terr !== 1'b1 || bus.mem_valid !== 1'b0) $display("FAIL timeout_sticky: terr=%b valid=%b required 1 0", terr, bus.mem_valid);
    else passed++;
    do_reset();
    total++;
    if (terr !== 1'b0) $display("FAIL timeout_clear: terr=%b required 0", terr);
    else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_tie();
    test_abort();
    test_saturation();
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    total++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d completions outstanding, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shared_port_arbiter.md
Name: shared_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one memory/ALU-side port between requester 0 (e.g. instruction fetch) and requester 1 (e.g. load/store).
- Owns the select of the 2:1 data mux in front of the shared port. Sequences request/grant/done handshakes and keeps per-requester grant counts for performance debug.
- Sits between the CPU front-end/back-end request paths and the shared resource.

Parameters:
- dataWidth, 32, width of address and write-data buses
- cntWidth, 16, width of per-requester saturating grant counters
- maxHold, 64, cycle limit for one grant (used only with the optional feature)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- req0, req1  input  1 each  request, held high until the matching done pulse
- addr0, addr1  input  dataWidth each  request address
- wData0, wData1  input  dataWidth each  write data
- memDone  input  1  shared port completes the current transaction this cycle
- gnt0, gnt1  output  1 each  registered grant, one-hot or both low
- done0, done1  output  1 each  completion pulse: memDone & gntX
- memValid  output  1  transaction active on the shared port (gnt0 | gnt1)
- sel  output  1  mux select; 1 selects requester 1
- memAddr, memWData  output  dataWidth each  muxed request fields (sel ? x1 : x0)
- grantCnt0, grantCnt1  output  cntWidth each  grants issued, saturating
- timeoutErr  output  1  sticky error flag (optional feature only, otherwise tied 0)

Behaviour:
Reset (rst_n low at a clk edge):
- state IDLE; gnt0 = gnt1 = 0; sel = 0; lastGrant = 1, so requester 0 wins the first tie.
- grantCnt0 = grantCnt1 = 0; holdCnt = 0; timeoutErr = 0.
- Reset mid-transaction drops the grant next edge; no done pulse is produced.

States: IDLE, GRANT0, GRANT1. gntX = (state == GRANTX), registered.

IDLE:
- Only reqX high -> GRANTX next edge.
- Both high -> GRANT of the requester != lastGrant.
- Neither high -> stay IDLE.
- Latency from req to gnt is 1 cycle.

GRANTX:
- memValid = 1.
- sel = X, registered and updated on grant entry. sel holds its value in IDLE and does not toggle.
- doneX = memDone & gntX, combinational, one cycle.

On memDone in GRANTX:
- Other requester's req high -> GRANT of the other requester next edge. Back-to-back, no IDLE bubble.
- Else own reqX still high (new transaction) -> stay GRANTX.
- Else -> IDLE.

Abort:
- reqX drops in GRANTX without memDone -> IDLE next edge, no doneX.
- memDone with neither gnt high is ignored.

lastGrant and counters:
- lastGrant updates to X on every entry into GRANTX, including a re-grant while staying in GRANTX.
- grantCntX increments on every entry or re-grant. It saturates at all-ones; no wrap.

holdCnt:
- Cleared on every grant entry or re-grant.
- Increments each cycle while in a GRANT state without memDone.

memAddr/memWData:
- Purely combinational from sel, 0-cycle path.
- Valid for the port only while memValid = 1.

Fairness:
- Both requesters continuously requesting strictly alternate: 0,1,0,1...

Optional Feature:
- Macro: SHARED_PORT_ARB_TIMEOUT_EN.
- Defined: when holdCnt reaches maxHold-1 with no memDone, the grant is forcibly released next edge. The FSM returns to IDLE, or goes to the other requester if it is requesting. timeoutErr sets and stays set until reset. No done pulse is generated for the aborted transaction.
- Not defined: holdCnt logic may be removed, grants are held indefinitely, and timeoutErr is constant 0.

Test Plan:
- Reset: rst_n=0 for 2 cycles, random inputs -> gnt0=gnt1=0, sel=0, memValid=0, both counters 0.
- Single requester: req0=1, addr0=0x100, memDone 3 cycles after gnt0 -> gnt0 rises 1 cycle after req0, memAddr=0x100, done0 one-cycle pulse, grantCnt0=1, IDLE after req0 drops.
- Tie from reset: req0=req1=1 same cycle, memDone 1 cycle into each grant -> grant order 0,1,0,1; sel toggles 0,1,0,1; no IDLE cycle between grants; grantCnt0=grantCnt1=2 after 4 transactions.
- Abort: gnt1 active, req1 drops with memDone=0 -> gnt1=0 next cycle, done1 never pulses, grantCnt1 unchanged.
- Saturation: cntWidth=4, 20 single-requester transactions on req0 -> grantCnt0 stops at 15.
- Timeout (macro defined, maxHold=8): gnt0 held, memDone never asserted, req1 high -> after 8 grant cycles gnt1=1, timeoutErr=1 and it stays 1 after further traffic until rst_n=0.
